// File: rtl/rng_request_arbiter_if.sv
// Client and generator signals of the shared-RNG arbiter.
// RNG_ARB_NIBBLE_EN adds the per-requester nibble-select and 4-bit generator nibble.
interface rng_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               en_rng;
  logic               rng_done;
  logic [DATA_W-1:0]  rng_data;
`ifdef RNG_ARB_NIBBLE_EN
  logic [NUM_REQ-1:0] req_nib;
  logic [3:0]         rng_nib;

  modport master (
    input  req, rng_done, rng_data, req_nib, rng_nib,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, en_rng
  );
  modport slave (
    output req, rng_done, rng_data, req_nib, rng_nib,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, en_rng
  );
`else
  modport master (
    input  req, rng_done, rng_data,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, en_rng
  );
  modport slave (
    output req, rng_done, rng_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, en_rng
  );
`endif
endinterface

// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter sharing one random generator among NUM_REQ clients, with a WAIT timeout.
// Optional feature macro: RNG_ARB_NIBBLE_EN (return only the generator nibble on request).
module rng_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic                   clock,
  input logic                   nrst,
  rng_request_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, winner, pick;
  logic               pick_vld;
  logic [CNT_W-1:0]   wait_cnt;
  logic               wait_hit;
  logic [DATA_W-1:0]  rsp_data_q, rng_word;
  logic               rsp_err_q;
  logic [NUM_REQ-1:0] onehot;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(rr_ptr, i)]) begin
        pick     = wrap_add(rr_ptr, i);
        pick_vld = 1'b1;
      end
    end
  end

  // wait_cnt holds the number of the current WAIT cycle (1..TIMEOUT).
  assign wait_hit = (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.rng_done || wait_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RNG_ARB_NIBBLE_EN
  logic nib_sel;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst)                           nib_sel <= 1'b0;
    else if (state == IDLE && pick_vld)  nib_sel <= bus.req_nib[pick];
  end

  assign rng_word = nib_sel ? {{(DATA_W-4){1'b0}}, bus.rng_nib} : bus.rng_data;
`else
  assign rng_word = bus.rng_data;
`endif

  // Done is checked before the timeout so a same-cycle done still returns data.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      rr_ptr     <= '0;
      winner     <= '0;
      wait_cnt   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (pick_vld) winner <= pick;
        START: wait_cnt <= CNT_W'(1);
        WAIT: begin
          if (bus.rng_done) begin
            rsp_data_q <= rng_word;
            rsp_err_q  <= 1'b0;
          end else if (wait_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    rr_ptr <= wrap_add(winner, 1);
        default: ;
      endcase
    end
  end

  assign onehot        = NUM_REQ'(1) << winner;
  assign bus.gnt       = (state != IDLE) ? onehot : '0;
  assign bus.rsp_valid = (state == RESP) ? onehot : '0;
  assign bus.en_rng    = (state == START);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
